// File: rtl/keypad_entry_ctrl.sv
// Keypad front end: debounce, encode, one load strobe per press, seconds tick.
// Build option: define KEYPAD_PRIORITY_EN to take the highest key of a multi-key press.
module keypad_entry_ctrl #(
    parameter int KEYS     = 10,
    parameter int CODE_W   = 4,
    parameter int DEBOUNCE = 2,
    parameter int CLK_DIV  = 100
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [KEYS-1:0]   keypad,
    input  logic              en,
    output logic [CODE_W-1:0] code,
    output logic              loadn,
    output logic              pgt_tick,
    output logic              multi_err
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEB,
        S_LOAD,
        S_HOLD,
        S_ERR
    } state_t;

    state_t            r_state, w_state;
    logic [KEYS-1:0]   r_kp_q;
    logic [KEYS-1:0]   r_pat, w_pat;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic [CODE_W-1:0] r_code, w_code;
    logic              r_loadn, w_loadn;
    logic              r_err, w_err;
    logic [DIV_W-1:0]  r_div, w_div;
    logic              r_tick, w_tick;
    logic [CODE_W-1:0] w_idx;
    logic              w_accept;
    logic              w_multi;

`ifdef KEYPAD_PRIORITY_EN
    assign w_accept = |r_kp_q;
    assign w_multi  = 1'b0;
`else
    logic w_onehot;
    assign w_onehot = (r_kp_q != '0) &&
                      ((r_kp_q & (r_kp_q - KEYS'(1))) == '0);
    assign w_accept = w_onehot;
    assign w_multi  = (r_kp_q != '0) && !w_onehot;
`endif

    // Ascending scan: the highest set bit wins for multi-bit patterns
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < KEYS; i++) begin
            if (r_pat[i]) w_idx = CODE_W'(i);
        end
    end

    always_comb begin
        w_state = r_state;
        w_pat   = r_pat;
        w_cnt   = r_cnt;
        w_code  = r_code;
        w_loadn = 1'b1;
        w_err   = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (en && w_accept) begin
                    w_pat   = r_kp_q;
                    w_cnt   = CNT_W'(1);
                    w_state = S_DEB;
                end else if (en && w_multi) begin
                    w_err   = 1'b1;
                    w_state = S_ERR;
                end
            end
            S_DEB: begin
                if (!en || (r_kp_q != r_pat)) begin
                    w_state = S_IDLE;
                end else if (r_cnt == CNT_W'(DEBOUNCE)) begin
                    w_loadn = 1'b0;
                    w_code  = w_idx;
                    w_state = S_LOAD;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_LOAD: w_state = S_HOLD;
            S_HOLD: begin
                if (r_kp_q == '0) w_state = S_IDLE;
            end
            S_ERR: begin
                if (r_kp_q == '0) begin
                    w_err   = 1'b0;
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // Tick is registered alongside the counter so it is high while div == CLK_DIV-1
    assign w_div  = (r_div == DIV_W'(CLK_DIV - 1)) ? '0 : r_div + DIV_W'(1);
    assign w_tick = (w_div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clock) begin
        r_kp_q <= keypad;
        if (!resetn) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_cnt   <= '0;
            r_code  <= '0;
            r_loadn <= 1'b1;
            r_err   <= 1'b0;
            r_div   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pat   <= w_pat;
            r_cnt   <= w_cnt;
            r_code  <= w_code;
            r_loadn <= w_loadn;
            r_err   <= w_err;
            r_div   <= w_div;
            r_tick  <= w_tick;
        end
    end

    assign code      = r_code;
    assign loadn     = r_loadn;
    assign pgt_tick  = r_tick;
    assign multi_err = r_err;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: vector table plus hand-written sequences.
// Expectations follow KEYPAD_PRIORITY_EN when it is defined for the build.
module tb_keypad_entry_ctrl;

    logic       clock;
    logic       resetn;
    logic       en;
    logic [9:0] keypad;
    logic [3:0] code;
    logic       loadn;
    logic       pgt_tick;
    logic       multi_err;

    int n_chk  = 0;
    int n_fail = 0;

    keypad_entry_ctrl #(
        .KEYS    (10),
        .CODE_W  (4),
        .DEBOUNCE(2),
        .CLK_DIV (100)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .keypad   (keypad),
        .en       (en),
        .code     (code),
        .loadn    (loadn),
        .pgt_tick (pgt_tick),
        .multi_err(multi_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rstn;
        logic       en;
        logic [9:0] kp;
        int         n;
        logic       xl;
        logic [3:0] xc;
        logic       xe;
    } vec_t;

    vec_t tbl[$];

`ifdef KEYPAD_PRIORITY_EN
    localparam logic [3:0] PRE_EN_CODE = 4'd1;
`else
    localparam logic [3:0] PRE_EN_CODE = 4'd9;
`endif

    function automatic void add(input logic rstn, input logic e,
                                input logic [9:0] kp, input int n,
                                input logic xl, input logic [3:0] xc,
                                input logic xe);
        vec_t v;
        v.rstn = rstn;
        v.en   = e;
        v.kp   = kp;
        v.n    = n;
        v.xl   = xl;
        v.xc   = xc;
        v.xe   = xe;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h want %0h", nm, idx, got, want);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        en     = 1'b0;
        keypad = '0;

        // reset with a key on the bus
        add(0, 0, 10'b0000000001, 3, 1, 4'd0, 0);
        add(1, 0, 10'b0000000000, 1, 1, 4'd0, 0);
        // key 4 held 50 cycles: strobe on the 4th edge of the press
        add(1, 1, 10'b0000010000, 3, 1, 4'd0, 0);
        add(1, 1, 10'b0000010000, 1, 0, 4'd4, 0);
        add(1, 1, 10'b0000010000, 46, 1, 4'd4, 0);
        add(1, 1, 10'b0000000000, 2, 1, 4'd4, 0);
        // key 9
        add(1, 1, 10'b1000000000, 3, 1, 4'd4, 0);
        add(1, 1, 10'b1000000000, 1, 0, 4'd9, 0);
        add(1, 1, 10'b1000000000, 1, 1, 4'd9, 0);
        add(1, 1, 10'b0000000000, 2, 1, 4'd9, 0);
        // one-cycle bounce on key 2
        add(1, 1, 10'b0000000100, 1, 1, 4'd9, 0);
        add(1, 1, 10'b0000000000, 5, 1, 4'd9, 0);
        // two keys held
        add(1, 1, 10'b0000000011, 1, 1, 4'd9, 0);
`ifdef KEYPAD_PRIORITY_EN
        add(1, 1, 10'b0000000011, 2, 1, 4'd9, 0);
        add(1, 1, 10'b0000000011, 1, 0, 4'd1, 0);
        add(1, 1, 10'b0000000011, 10, 1, 4'd1, 0);
        add(1, 1, 10'b0000000000, 3, 1, 4'd1, 0);
`else
        add(1, 1, 10'b0000000011, 11, 1, 4'd9, 1);
        add(1, 1, 10'b0000000000, 1, 1, 4'd9, 1);
        add(1, 1, 10'b0000000000, 2, 1, 4'd9, 0);
`endif
        // key 1 with en low, then en raised while held
        add(1, 0, 10'b0000000010, 20, 1, PRE_EN_CODE, 0);
        add(1, 1, 10'b0000000010, 2, 1, PRE_EN_CODE, 0);
        add(1, 1, 10'b0000000010, 1, 0, 4'd1, 0);
        add(1, 1, 10'b0000000010, 3, 1, 4'd1, 0);
        add(1, 1, 10'b0000000000, 2, 1, 4'd1, 0);

        foreach (tbl[r]) begin
            for (int j = 0; j < tbl[r].n; j++) begin
                resetn = tbl[r].rstn;
                en     = tbl[r].en;
                keypad = tbl[r].kp;
                step();
                chk("loadn", r, loadn, tbl[r].xl);
                chk("code", r, code, tbl[r].xc);
                chk("multi_err", r, multi_err, tbl[r].xe);
                if (!tbl[r].rstn) chk("rst_tick", r, pgt_tick, 0);
            end
        end

        // second key added during debounce aborts the press
        en     = 1'b1;
        keypad = 10'b0000100000;
        step();
        step();
        keypad = 10'b0001100000;
        step();
        chk("add_key_loadn", 0, loadn, 1);
        step();
        chk("add_key_loadn", 1, loadn, 1);
        keypad = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("add_key_tail", i, loadn, 1);
            chk("add_key_code", i, code, 4'd1);
        end

        // reset asserted while in LOAD
        keypad = 10'b0010000000;
        step();
        step();
        step();
        chk("pre_rst_loadn", 0, loadn, 1);
        step();
        chk("pre_rst_loadn", 1, loadn, 0);
        chk("pre_rst_code", 0, code, 4'd7);
        resetn = 1'b0;
        step();
        chk("rst_load_loadn", 0, loadn, 1);
        chk("rst_load_code", 0, code, 4'd0);
        keypad = '0;
        en     = 1'b0;
        resetn = 1'b1;
        step();
        chk("post_rst_loadn", 0, loadn, 1);
        chk("post_rst_code", 0, code, 4'd0);

        // seconds tick from a fresh reset, then reset mid-run
        resetn = 1'b0;
        step();
        chk("tick_rst", 0, pgt_tick, 0);
        resetn = 1'b1;
        for (int n = 1; n < 250; n++) begin
            step();
            chk("tick", n, pgt_tick, (n % 100) == 99);
        end
        resetn = 1'b0;
        step();
        chk("tick_rst", 1, pgt_tick, 0);
        resetn = 1'b1;
        for (int m = 1; m <= 150; m++) begin
            step();
            chk("tick_after_rst", m, pgt_tick, (m % 100) == 99);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
